// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator for the instruction fetch stage
// Issues one fetch address per cycle, redirects on jumps, defers jumps during stalls.
module pc_gen #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            INC      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_jump_valid,
  input  logic [AW-1:0] i_jump_pc,
  input  logic          i_holding,
  input  logic          i_halt_req,
  output logic          o_pc_valid,
  output logic [AW-1:0] o_pc,
  output logic          o_jump_err,
  output logic          o_halted
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  localparam logic [AW-1:0] INC_V = AW'(INC);

  logic [1:0]    state;
  logic [AW-1:0] pend_pc;
  logic          misaligned;

  // Alignment is always judged on the low two bits, whatever INC is.
  assign misaligned = i_jump_valid && (i_jump_pc[1:0] != 2'b00);

  assign o_pc_valid = (state == RUN) || (state == PEND);
  assign o_halted   = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      o_pc       <= RESET_PC;
      o_jump_err <= 1'b0;
      pend_pc    <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (misaligned) begin
            o_jump_err <= 1'b1;
            state      <= HALT;
          end else if (i_jump_valid && !i_holding) begin
            o_pc <= i_jump_pc;
          end else if (i_jump_valid) begin
            pend_pc <= i_jump_pc;
            state   <= PEND;
          end else if (i_halt_req && !i_holding) begin
            state <= HALT;
          end else if (!i_holding) begin
            o_pc <= o_pc + INC_V;
          end
        end
        PEND: begin
          // o_pc stays put until the outstanding fetch completes; newest jump wins.
          if (misaligned) begin
            o_jump_err <= 1'b1;
            state      <= HALT;
          end else if (!i_holding) begin
            o_pc  <= i_jump_valid ? i_jump_pc : pend_pc;
            state <= RUN;
          end else if (i_jump_valid) begin
            pend_pc <= i_jump_pc;
          end
        end
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized self-checking bench for pc_gen against a behavioural model
// Two instances share stimulus: default RESET_PC and RESET_PC near the top of the address space.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_valid;
  logic [31:0] jump_pc;
  logic        holding;
  logic        halt_req;

  logic        pc_valid0, jump_err0, halted0;
  logic [31:0] pc0;
  logic        pc_valid1, jump_err1, halted1;
  logic [31:0] pc1;

  int tests = 0;
  int fails = 0;

  logic [31:0] rp        [2];
  logic [31:0] m_pc      [2];
  logic [31:0] m_pend_pc [2];
  bit          m_boot    [2];
  bit          m_pending [2];
  bit          m_halted  [2];
  bit          m_err     [2];

  always #5 clk = ~clk;

  pc_gen u_dut0 (
    .clk(clk), .rst(rst), .i_jump_valid(jump_valid), .i_jump_pc(jump_pc),
    .i_holding(holding), .i_halt_req(halt_req), .o_pc_valid(pc_valid0),
    .o_pc(pc0), .o_jump_err(jump_err0), .o_halted(halted0)
  );

  pc_gen #(.RESET_PC(32'hFFFF_FFF8)) u_dut1 (
    .clk(clk), .rst(rst), .i_jump_valid(jump_valid), .i_jump_pc(jump_pc),
    .i_holding(holding), .i_halt_req(halt_req), .o_pc_valid(pc_valid1),
    .o_pc(pc1), .o_jump_err(jump_err1), .o_halted(halted1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: fetch proceeds unless booting, halted or stalled; a stalled jump waits.
  task automatic model(input int k, input bit r, input bit jv, input logic [31:0] jpc,
                       input bit hold, input bit hr);
    if (r) begin
      m_boot[k] = 1; m_pc[k] = rp[k]; m_pending[k] = 0; m_halted[k] = 0; m_err[k] = 0;
    end else if (m_boot[k]) begin
      m_boot[k] = 0;
    end else if (m_halted[k]) begin
      m_halted[k] = 1;
    end else if (jv && (jpc % 4 != 0)) begin
      m_err[k] = 1; m_halted[k] = 1; m_pending[k] = 0;
    end else if (m_pending[k]) begin
      if (!hold) begin
        m_pc[k] = jv ? jpc : m_pend_pc[k];
        m_pending[k] = 0;
      end else if (jv) begin
        m_pend_pc[k] = jpc;
      end
    end else if (jv) begin
      if (hold) begin
        m_pending[k] = 1; m_pend_pc[k] = jpc;
      end else begin
        m_pc[k] = jpc;
      end
    end else if (hr && !hold) begin
      m_halted[k] = 1;
    end else if (!hold) begin
      m_pc[k] = m_pc[k] + 32'd4;
    end
  endtask

  task automatic step(input bit r, input bit jv, input logic [31:0] jpc,
                      input bit hold, input bit hr);
    rst = r; jump_valid = jv; jump_pc = jpc; holding = hold; halt_req = hr;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model(k, r, jv, jpc, hold, hr);
    #1;
    check("pc0",     pc0,       m_pc[0]);
    check("valid0",  {31'd0, pc_valid0}, {31'd0, !m_boot[0] && !m_halted[0]});
    check("err0",    {31'd0, jump_err0}, {31'd0, m_err[0]});
    check("halted0", {31'd0, halted0},   {31'd0, m_halted[0]});
    check("pc1",     pc1,       m_pc[1]);
    check("valid1",  {31'd0, pc_valid1}, {31'd0, !m_boot[1] && !m_halted[1]});
    check("err1",    {31'd0, jump_err1}, {31'd0, m_err[1]});
    check("halted1", {31'd0, halted1},   {31'd0, m_halted[1]});
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] jpc;
    bit jv, hold, hr, r;
    rp[0] = 32'h0000_0000;
    rp[1] = 32'hFFFF_FFF8;
    rst = 1; jump_valid = 0; jump_pc = 0; holding = 0; halt_req = 0;
    @(negedge clk);

    // Reset, boot cycle, then sequential fetch (and wrap on the second instance)
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("t1_boot_valid", {31'd0, pc_valid0}, 32'd0);
    check("t1_boot_pc", pc0, 32'h0);
    step(0, 0, 0, 0, 0);
    check("t1_first_valid", {31'd0, pc_valid0}, 32'd1);
    check("t6_wrap_a", pc1, 32'hFFFF_FFF8);
    step(0, 0, 0, 0, 0);
    check("t6_wrap_b", pc1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    check("t1_pc8", pc0, 32'h8);
    check("t6_wrap_c", pc1, 32'h0);

    // Stall at 8 then release
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    check("t2_hold", pc0, 32'h8);
    step(0, 0, 0, 0, 0);
    check("t2_release", pc0, 32'hC);

    // Immediate jump
    step(0, 1, 32'h100, 0, 0);
    check("t3_jump", pc0, 32'h100);
    step(0, 0, 0, 0, 0);
    check("t3_next", pc0, 32'h104);

    // Deferred jumps: latest wins; coincident jump on release wins
    step(0, 1, 32'h200, 1, 0);
    step(0, 1, 32'h300, 1, 0);
    step(0, 0, 0, 1, 0);
    check("t4_held", pc0, 32'h104);
    step(0, 0, 0, 0, 0);
    check("t4_deferred", pc0, 32'h300);
    step(0, 1, 32'h400, 1, 0);
    step(0, 1, 32'h500, 0, 0);
    check("t4_coincident", pc0, 32'h500);

    // Halt request waits for the stall to clear
    step(0, 0, 0, 1, 1);
    check("t6_no_halt", {31'd0, halted0}, 32'd0);
    step(0, 0, 0, 0, 1);
    check("t6_halt_valid", {31'd0, pc_valid0}, 32'd0);

    // Misaligned jump is sticky until reset
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h102, 0, 0);
    check("t5_err", {31'd0, jump_err0}, 32'd1);
    step(0, 1, 32'h200, 0, 0);
    step(0, 1, 32'h203, 1, 0);
    check("t5_sticky", {31'd0, halted0}, 32'd1);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 79) == 0);
      jv   = ($urandom_range(0, 5) == 0);
      hold = ($urandom_range(0, 2) == 0);
      hr   = ($urandom_range(0, 39) == 0);
      jpc  = $urandom;
      if ($urandom_range(0, 9) != 0) jpc[1:0] = 2'b00;
      step(r, jv, jpc, hold, hr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
